// File: rtl/nes_joypad_responder_if.sv
// Pad-side bundle of the NES joypad link: button sources, console pins and debug outputs.
// The master modport is the console/stimulus side, the slave modport is the responder.
interface nes_joypad_responder_if;
    logic [7:0] i_btn;
    logic [7:0] i_btn2;
    logic [1:0] i_turbo;
    logic       joy_strobe;
    logic       joy_clock;
    logic       joy_data;
    logic [4:0] o_bit_count;
    logic       o_turbo_phase;

    modport master (
        output i_btn,
        output i_btn2,
        output i_turbo,
        output joy_strobe,
        output joy_clock,
        input  joy_data,
        input  o_bit_count,
        input  o_turbo_phase
    );

    modport slave (
        input  i_btn,
        input  i_btn2,
        input  i_turbo,
        input  joy_strobe,
        input  joy_clock,
        output joy_data,
        output o_bit_count,
        output o_turbo_phase
    );
endinterface

// File: rtl/nes_joypad_responder.sv
// Controller side of the NES serial joypad link: a 4021-style parallel-load / serial-shift
// responder with optional A/B turbo and an optional 24-bit Four Score frame.
module nes_joypad_responder #(
    parameter int         C_sync_stages = 2,
    parameter int         C_fourscore   = 0,
    parameter logic [7:0] C_signature   = 8'h10,
    parameter int         C_turbo_div   = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    nes_joypad_responder_if.slave bus
);

    localparam int         N          = (C_fourscore != 0) ? 24 : 8;
    localparam logic [7:0] TURBO_LAST = 8'(C_turbo_div - 1);

    // Turbo gating: a turbo-enabled button reads released during the low phase.
    function automatic logic [7:0] turbo_mask(input logic [7:0] btn,
                                              input logic [1:0] turbo,
                                              input logic       phase);
        logic [7:0] r;
        r = btn;
        if (turbo[0] && !phase) begin
            r[0] = 1'b0;
        end else begin
            r[0] = btn[0];
        end
        if (turbo[1] && !phase) begin
            r[1] = 1'b0;
        end else begin
            r[1] = btn[1];
        end
        return r;
    endfunction

    logic [C_sync_stages-1:0] strobe_sync_q, strobe_sync_d;
    logic [C_sync_stages-1:0] clock_sync_q,  clock_sync_d;
    logic                     s_strobe, s_clock;
    logic                     s_clock_d_q, s_clock_d_d;
    logic                     s_strobe_d_q, s_strobe_d_d;
    logic                     shift_evt_s, latch_end_s;
    logic [7:0]               btn_masked_s;
    logic [N-1:0]             load_val_s;
    logic [N-1:0]             sr_q, sr_d;
    logic [4:0]               bit_count_q, bit_count_d;
    logic                     joy_data_q, joy_data_d;
    logic [7:0]               tcnt_q, tcnt_d;
    logic                     turbo_phase_q, turbo_phase_d;

    assign s_strobe     = strobe_sync_q[C_sync_stages-1];
    assign s_clock      = clock_sync_q[C_sync_stages-1];
    assign btn_masked_s = turbo_mask(bus.i_btn, bus.i_turbo, turbo_phase_q);

    // The shift is keyed on the falling edge of the shift clock; strobe suppresses it.
    assign shift_evt_s = s_clock_d_q & ~s_clock & ~s_strobe;
    assign latch_end_s = s_strobe_d_q & ~s_strobe;

    if (C_fourscore != 0) begin : g_fourscore
        assign load_val_s = {C_signature, bus.i_btn2, btn_masked_s};
    end else begin : g_single
        logic unused_btn2_s;
        assign unused_btn2_s = ^bus.i_btn2;
        assign load_val_s    = btn_masked_s;
    end

    // Synchronizer chains and edge-detect history for the two console pins.
    always_comb begin
        strobe_sync_d = {strobe_sync_q[C_sync_stages-2:0], bus.joy_strobe};
        clock_sync_d  = {clock_sync_q[C_sync_stages-2:0], bus.joy_clock};
        s_clock_d_d   = s_clock;
        s_strobe_d_d  = s_strobe;
    end

    // Shift register and bit counter: parallel load while strobed, else shift in ones.
    always_comb begin
        sr_d        = sr_q;
        bit_count_d = bit_count_q;
        if (s_strobe) begin
            sr_d        = load_val_s;
            bit_count_d = 5'd0;
        end else if (shift_evt_s) begin
            sr_d = {1'b1, sr_q[N-1:1]};
            if (bit_count_q != 5'd31) begin
                bit_count_d = bit_count_q + 5'd1;
            end else begin
                bit_count_d = bit_count_q;
            end
        end else begin
            sr_d        = sr_q;
            bit_count_d = bit_count_q;
        end
    end

    // Data line is registered and active-low.
    always_comb begin
        joy_data_d = ~sr_q[0];
    end

    // Turbo divider: the phase only moves at latch end, so it affects the next frame's load.
    always_comb begin
        tcnt_d        = tcnt_q;
        turbo_phase_d = turbo_phase_q;
        if (latch_end_s) begin
            if (tcnt_q == TURBO_LAST) begin
                tcnt_d        = 8'd0;
                turbo_phase_d = ~turbo_phase_q;
            end else begin
                tcnt_d        = tcnt_q + 8'd1;
                turbo_phase_d = turbo_phase_q;
            end
        end else begin
            tcnt_d        = tcnt_q;
            turbo_phase_d = turbo_phase_q;
        end
    end

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            strobe_sync_q <= '0;
            clock_sync_q  <= '0;
            s_clock_d_q   <= 1'b0;
            s_strobe_d_q  <= 1'b0;
            sr_q          <= '1;
            bit_count_q   <= 5'd0;
            joy_data_q    <= 1'b0;
            tcnt_q        <= 8'd0;
            turbo_phase_q <= 1'b1;
        end else begin
            strobe_sync_q <= strobe_sync_d;
            clock_sync_q  <= clock_sync_d;
            s_clock_d_q   <= s_clock_d_d;
            s_strobe_d_q  <= s_strobe_d_d;
            sr_q          <= sr_d;
            bit_count_q   <= bit_count_d;
            joy_data_q    <= joy_data_d;
            tcnt_q        <= tcnt_d;
            turbo_phase_q <= turbo_phase_d;
        end
    end

    assign bus.joy_data      = joy_data_q;
    assign bus.o_bit_count   = bit_count_q;
    assign bus.o_turbo_phase = turbo_phase_q;

endmodule

// File: tb/tb_nes_joypad_responder.sv
// Self-checking bench: an 8-bit responder and a Four Score responder driven by the same
// console waveform, compared against a frame-level model of the joypad protocol.
module tb_nes_joypad_responder;

    logic clk = 1'b0;
    logic resetn;
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   latch_cnt = 0;

    always #5 clk = ~clk;

    nes_joypad_responder_if bus8();
    nes_joypad_responder_if busfs();

    nes_joypad_responder dut8 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus8.slave)
    );

    nes_joypad_responder #(
        .C_sync_stages (3),
        .C_fourscore   (1)
    ) dut_fs (
        .clk    (clk),
        .resetn (resetn),
        .bus    (busfs.slave)
    );

    // ---------------- reference model ----------------
    function automatic logic model_phase(input int lc);
        return ((lc / 3) % 2) == 0;
    endfunction

    function automatic logic [7:0] model_mask(input logic [7:0] b, input logic [1:0] t,
                                              input logic ph);
        logic [7:0] r;
        r = b;
        if (!ph && t[0]) r[0] = 1'b0;
        if (!ph && t[1]) r[1] = 1'b0;
        return r;
    endfunction

    // Line level seen after idx shifts: inverted frame bit, then low once the frame is exhausted.
    function automatic logic model_bit(input logic [23:0] w, input int n, input int idx);
        if (idx < n) return ~w[idx];
        return 1'b0;
    endfunction

    function automatic logic [4:0] model_count(input int np);
        if (np > 31) return 5'd31;
        return 5'(np);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_inputs(input logic [7:0] b, input logic [7:0] b2, input logic [1:0] t);
        bus8.i_btn  = b;  bus8.i_btn2  = b2; bus8.i_turbo  = t;
        busfs.i_btn = b;  busfs.i_btn2 = b2; busfs.i_turbo = t;
    endtask

    task automatic set_pins(input logic st, input logic ck);
        bus8.joy_strobe  = st; bus8.joy_clock  = ck;
        busfs.joy_strobe = st; busfs.joy_clock = ck;
    endtask

    task automatic do_strobe();
        @(negedge clk);
        set_pins(1'b1, 1'b1);
        wait_cyc(12);
        set_pins(1'b0, 1'b1);
        wait_cyc(8);
        latch_cnt++;
    endtask

    task automatic do_pulse(input int lo, input int hi);
        set_pins(1'b0, 1'b0);
        wait_cyc(lo);
        set_pins(1'b0, 1'b1);
        wait_cyc(hi);
    endtask

    task automatic read_frame(input int np, output logic [63:0] s8, output logic [63:0] sfs,
                              output logic [4:0] c8, output logic [4:0] cfs);
        s8  = 64'd0;
        sfs = 64'd0;
        do_strobe();
        s8[0]  = bus8.joy_data;
        sfs[0] = busfs.joy_data;
        for (int j = 1; j <= np; j++) begin
            do_pulse(6, 6);
            s8[j]  = bus8.joy_data;
            sfs[j] = busfs.joy_data;
        end
        c8  = bus8.o_bit_count;
        cfs = busfs.o_bit_count;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        wait_cyc(3);
        resetn = 1'b1;
        latch_cnt = 0;
        wait_cyc(8);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_inputs(8'h00, 8'h00, 2'b00);
        set_pins(1'b0, 1'b1);
        resetn = 1'b0;
        wait_cyc(3);
        n_cmp++; if (bus8.joy_data !== 1'b0) begin n_bad++; $display("FAIL reset_data8 got %b exp 0", bus8.joy_data); end
        n_cmp++; if (bus8.o_bit_count !== 5'd0) begin n_bad++; $display("FAIL reset_count8 got %0d exp 0", bus8.o_bit_count); end
        n_cmp++; if (bus8.o_turbo_phase !== 1'b1) begin n_bad++; $display("FAIL reset_phase8 got %b exp 1", bus8.o_turbo_phase); end
        n_cmp++; if (busfs.joy_data !== 1'b0) begin n_bad++; $display("FAIL reset_datafs got %b exp 0", busfs.joy_data); end
        n_cmp++; if (busfs.o_turbo_phase !== 1'b1) begin n_bad++; $display("FAIL reset_phasefs got %b exp 1", busfs.o_turbo_phase); end
        resetn = 1'b1;
        latch_cnt = 0;
        wait_cyc(8);
        n_cmp++; if (bus8.joy_data !== 1'b0 || bus8.o_bit_count !== 5'd0) begin
            n_bad++; $display("FAIL post_reset8 data %b count %0d exp 0/0", bus8.joy_data, bus8.o_bit_count);
        end
    endtask

    task automatic test_read8();
        logic [63:0] s8, sfs;
        logic [4:0]  c8, cfs;
        logic [9:0]  want;
        logic [23:0] w;
        want = 10'b0001101110;  // LSB first: 0,1,1,1,0,1,1,0,0,0
        set_inputs(8'b1001_0001, 8'h00, 2'b00);
        w = {16'h0000, model_mask(8'b1001_0001, 2'b00, model_phase(latch_cnt))};
        read_frame(10, s8, sfs, c8, cfs);
        for (int j = 0; j < 10; j++) begin
            n_cmp++;
            if (s8[j] !== want[j] || s8[j] !== model_bit(w, 8, j)) begin
                n_bad++; $display("FAIL read8 sample%0d got %b exp %b", j, s8[j], want[j]);
            end
        end
        n_cmp++; if (c8 !== 5'd10) begin n_bad++; $display("FAIL read8_count got %0d exp 10", c8); end
    endtask

    task automatic test_fourscore();
        logic [63:0] s8, sfs;
        logic [4:0]  c8, cfs;
        logic [23:0] w;
        set_inputs(8'h01, 8'h80, 2'b00);
        w = {8'h10, 8'h80, model_mask(8'h01, 2'b00, model_phase(latch_cnt))};
        read_frame(26, s8, sfs, c8, cfs);
        for (int j = 0; j <= 26; j++) begin
            n_cmp++;
            if (sfs[j] !== model_bit(w, 24, j)) begin
                n_bad++; $display("FAIL fourscore bit%0d got %b exp %b", j, sfs[j], model_bit(w, 24, j));
            end
        end
        n_cmp++; if (sfs[15] !== 1'b0 || sfs[20] !== 1'b0 || sfs[16] !== 1'b1) begin
            n_bad++; $display("FAIL fourscore_marks b15 %b b16 %b b20 %b exp 0 1 0", sfs[15], sfs[16], sfs[20]);
        end
        n_cmp++; if (cfs !== 5'd26) begin n_bad++; $display("FAIL fourscore_count got %0d exp 26", cfs); end
    endtask

    task automatic test_random();
        logic [63:0] s8, sfs;
        logic [4:0]  c8, cfs;
        logic [23:0] w8, wfs;
        logic [7:0]  b, b2, m;
        logic [1:0]  t;
        int          np;
        for (int f = 0; f < 8; f++) begin
            b  = 8'($urandom);
            b2 = 8'($urandom);
            t  = 2'($urandom_range(0, 3));
            np = $urandom_range(0, 30);
            set_inputs(b, b2, t);
            m   = model_mask(b, t, model_phase(latch_cnt));
            w8  = {16'h0000, m};
            wfs = {8'h10, b2, m};
            read_frame(np, s8, sfs, c8, cfs);
            for (int j = 0; j <= np; j++) begin
                n_cmp++;
                if (s8[j] !== model_bit(w8, 8, j) || sfs[j] !== model_bit(wfs, 24, j)) begin
                    n_bad++; $display("FAIL random f%0d bit%0d got %b/%b exp %b/%b", f, j,
                                      s8[j], sfs[j], model_bit(w8, 8, j), model_bit(wfs, 24, j));
                end
            end
            n_cmp++;
            if (c8 !== model_count(np) || cfs !== model_count(np)) begin
                n_bad++; $display("FAIL random_count f%0d got %0d/%0d exp %0d", f, c8, cfs, model_count(np));
            end
        end
    endtask

    task automatic test_saturate();
        logic [63:0] s8, sfs;
        logic [4:0]  c8, cfs;
        set_inputs(8'h5A, 8'hA5, 2'b00);
        read_frame(35, s8, sfs, c8, cfs);
        n_cmp++; if (c8 !== 5'd31 || cfs !== 5'd31) begin
            n_bad++; $display("FAIL saturate got %0d/%0d exp 31", c8, cfs);
        end
        n_cmp++; if (s8[35] !== 1'b0 || sfs[35] !== 1'b0) begin
            n_bad++; $display("FAIL saturate_data got %b/%b exp 0", s8[35], sfs[35]);
        end
    endtask

    task automatic test_coincide();
        logic [63:0] s8, sfs;
        logic [4:0]  c8, cfs;
        logic [23:0] w;
        set_inputs(8'b0110_1100, 8'h00, 2'b00);
        read_frame(3, s8, sfs, c8, cfs);
        w = {16'h0000, model_mask(8'b0110_1100, 2'b00, model_phase(latch_cnt))};
        @(negedge clk);
        set_pins(1'b1, 1'b0);
        wait_cyc(12);
        n_cmp++; if (bus8.o_bit_count !== 5'd0) begin n_bad++; $display("FAIL coincide_count got %0d exp 0", bus8.o_bit_count); end
        n_cmp++; if (bus8.joy_data !== model_bit(w, 8, 0)) begin
            n_bad++; $display("FAIL coincide_data got %b exp %b", bus8.joy_data, model_bit(w, 8, 0));
        end
        set_pins(1'b1, 1'b1);
        wait_cyc(6);
        set_pins(1'b0, 1'b1);
        wait_cyc(8);
        latch_cnt++;
        n_cmp++; if (bus8.o_bit_count !== 5'd0 || bus8.joy_data !== model_bit(w, 8, 0)) begin
            n_bad++; $display("FAIL coincide_after count %0d data %b exp 0 %b", bus8.o_bit_count, bus8.joy_data, model_bit(w, 8, 0));
        end
        do_pulse(6, 6);
        n_cmp++; if (bus8.o_bit_count !== 5'd1 || bus8.joy_data !== model_bit(w, 8, 1)) begin
            n_bad++; $display("FAIL coincide_shift count %0d data %b exp 1 %b", bus8.o_bit_count, bus8.joy_data, model_bit(w, 8, 1));
        end
    endtask

    task automatic test_turbo();
        logic [63:0] s8, sfs;
        logic [4:0]  c8, cfs;
        logic [23:0] wfs;
        logic        exp_a;
        apply_reset();
        set_inputs(8'h03, 8'h00, 2'b01);
        for (int f = 0; f < 12; f++) begin
            wfs = {8'h10, 8'h00, model_mask(8'h03, 2'b01, model_phase(latch_cnt))};
            exp_a = ((f / 3) % 2 == 0) ? 1'b0 : 1'b1;
            read_frame(1, s8, sfs, c8, cfs);
            n_cmp++; if (s8[0] !== exp_a) begin n_bad++; $display("FAIL turbo_a frame%0d got %b exp %b", f, s8[0], exp_a); end
            n_cmp++; if (s8[1] !== 1'b0) begin n_bad++; $display("FAIL turbo_b frame%0d got %b exp 0", f, s8[1]); end
            n_cmp++; if (sfs[0] !== model_bit(wfs, 24, 0)) begin
                n_bad++; $display("FAIL turbo_fs frame%0d got %b exp %b", f, sfs[0], model_bit(wfs, 24, 0));
            end
            n_cmp++; if (bus8.o_turbo_phase !== model_phase(latch_cnt)) begin
                n_bad++; $display("FAIL turbo_phase frame%0d got %b exp %b", f, bus8.o_turbo_phase, model_phase(latch_cnt));
            end
        end
    endtask

    task automatic test_midframe_reset();
        logic [63:0] s8, sfs;
        logic [4:0]  c8, cfs;
        logic [23:0] w;
        logic [7:0]  b;
        b = 8'($urandom) | 8'h01;
        set_inputs(b, 8'h3C, 2'b00);
        read_frame(4, s8, sfs, c8, cfs);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        n_cmp++; if (bus8.joy_data !== 1'b0 || bus8.o_bit_count !== 5'd0) begin
            n_bad++; $display("FAIL midreset8 data %b count %0d exp 0/0", bus8.joy_data, bus8.o_bit_count);
        end
        n_cmp++; if (busfs.joy_data !== 1'b0 || busfs.o_bit_count !== 5'd0) begin
            n_bad++; $display("FAIL midresetfs data %b count %0d exp 0/0", busfs.joy_data, busfs.o_bit_count);
        end
        wait_cyc(3);
        resetn = 1'b1;
        latch_cnt = 0;
        wait_cyc(8);
        w = {16'h0000, model_mask(b, 2'b00, model_phase(latch_cnt))};
        read_frame(8, s8, sfs, c8, cfs);
        for (int j = 0; j <= 8; j++) begin
            n_cmp++;
            if (s8[j] !== model_bit(w, 8, j)) begin
                n_bad++; $display("FAIL midreset_read bit%0d got %b exp %b", j, s8[j], model_bit(w, 8, j));
            end
        end
    endtask

    task automatic test_glitch();
        logic [63:0] s8, sfs;
        logic [4:0]  c8, cfs, g8;
        logic [23:0] w;
        set_inputs(8'b1010_0110, 8'h00, 2'b00);
        w = {16'h0000, model_mask(8'b1010_0110, 2'b00, model_phase(latch_cnt))};
        read_frame(0, s8, sfs, c8, cfs);
        do_pulse(1, 8);
        g8 = bus8.o_bit_count;
        n_cmp++; if (g8 > 5'd1) begin n_bad++; $display("FAIL glitch_short got %0d exp <=1", g8); end
        do_pulse(3, 8);
        n_cmp++; if (bus8.o_bit_count !== g8 + 5'd1) begin
            n_bad++; $display("FAIL glitch_long got %0d exp %0d", bus8.o_bit_count, g8 + 5'd1);
        end
        n_cmp++; if (bus8.joy_data !== model_bit(w, 8, int'(g8) + 1)) begin
            n_bad++; $display("FAIL glitch_data got %b exp %b", bus8.joy_data, model_bit(w, 8, int'(g8) + 1));
        end
    endtask

    initial begin
        test_reset();
        test_read8();
        test_fourscore();
        test_random();
        test_saturate();
        test_coincide();
        test_turbo();
        test_midframe_reset();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
